change_dispenser: RTL and testbench



---
 rtl/change_dispenser.sv | 151 +++++++++++++++
 tb/tb_change_dispenser.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Coin-out payout engine: pays a refund in 5-cent units as dimes first, then
// nickels, one coin per request/acknowledge handshake, and reports any shortfall.
module change_dispenser #(
  parameter int unsigned UNIT_W        = 6,
  parameter int unsigned EJECT_TIMEOUT = 255,
  parameter int unsigned GAP_CYCLES    = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [UNIT_W-1:0] refund_units,
  input  logic              dime_empty,
  input  logic              nickel_empty,
  input  logic              eject_ack,
  output logic              dime_eject,
  output logic              nickel_eject,
  output logic              busy,
  output logic              done,
  output logic [UNIT_W-1:0] shortfall,
  output logic              error
);

  localparam logic [2:0] S_IDLE         = 3'd0;
  localparam logic [2:0] S_SELECT       = 3'd1;
  localparam logic [2:0] S_EJECT_DIME   = 3'd2;
  localparam logic [2:0] S_EJECT_NICKEL = 3'd3;
  localparam logic [2:0] S_GAP          = 3'd4;
  localparam logic [2:0] S_DONE         = 3'd5;

  // One counter serves both the eject wait and the inter-coin gap.
  localparam int unsigned CNT_MAX = (EJECT_TIMEOUT > GAP_CYCLES) ? EJECT_TIMEOUT : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  logic [2:0]        state_q,        state_d;
  logic [UNIT_W-1:0] remaining_q,    remaining_d;
  logic [CNT_W-1:0]  cnt_q,          cnt_d;
  logic              dime_jam_q,     dime_jam_d;
  logic              nickel_jam_q,   nickel_jam_d;
  logic              busy_q,         busy_d;
  logic              done_q,         done_d;
  logic              dime_eject_q,   dime_eject_d;
  logic              nickel_eject_q, nickel_eject_d;
  logic [UNIT_W-1:0] shortfall_q,    shortfall_d;
  logic              error_q,        error_d;

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    cnt_d        = cnt_q;
    dime_jam_d   = dime_jam_q;
    nickel_jam_d = nickel_jam_q;
    shortfall_d  = shortfall_q;
    error_d      = error_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          remaining_d  = refund_units;
          dime_jam_d   = 1'b0;
          nickel_jam_d = 1'b0;
          shortfall_d  = '0;
          error_d      = 1'b0;
          state_d      = S_SELECT;
        end
      end
      S_SELECT: begin
        cnt_d = '0;
        if (remaining_q == '0) begin
          state_d = S_DONE;
        end else if (remaining_q >= UNIT_W'(2) && !dime_empty && !dime_jam_q) begin
          state_d = S_EJECT_DIME;
        end else if (!nickel_empty && !nickel_jam_q) begin
          state_d = S_EJECT_NICKEL;
        end else begin
          state_d = S_DONE;
        end
        // Remaining is final once SELECT chooses DONE, so latch the report here.
        if (state_d == S_DONE) begin
          shortfall_d = remaining_q;
          error_d     = (remaining_q != '0);
        end
      end
      S_EJECT_DIME, S_EJECT_NICKEL: begin
        if (eject_ack) begin
          remaining_d = remaining_q - ((state_q == S_EJECT_DIME) ? UNIT_W'(2) : UNIT_W'(1));
          cnt_d       = '0;
          state_d     = S_GAP;
        end else if (cnt_q == CNT_W'(EJECT_TIMEOUT - 1)) begin
          if (state_q == S_EJECT_DIME) dime_jam_d = 1'b1;
          else                         nickel_jam_d = 1'b1;
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_SELECT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they align with it.
    busy_d         = (state_d != S_IDLE);
    done_d         = (state_d == S_DONE);
    dime_eject_d   = (state_d == S_EJECT_DIME);
    nickel_eject_d = (state_d == S_EJECT_NICKEL);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      remaining_q    <= '0;
      cnt_q          <= '0;
      dime_jam_q     <= 1'b0;
      nickel_jam_q   <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      dime_eject_q   <= 1'b0;
      nickel_eject_q <= 1'b0;
      shortfall_q    <= '0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      remaining_q    <= remaining_d;
      cnt_q          <= cnt_d;
      dime_jam_q     <= dime_jam_d;
      nickel_jam_q   <= nickel_jam_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      dime_eject_q   <= dime_eject_d;
      nickel_eject_q <= nickel_eject_d;
      shortfall_q    <= shortfall_d;
      error_q        <= error_d;
    end
  end

  assign dime_eject   = dime_eject_q;
  assign nickel_eject = nickel_eject_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign shortfall    = shortfall_q;
  assign error        = error_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: table of payouts with hand-computed
// coin counts and shortfall, plus reset, latency and ignored-start sequences.
module tb_change_dispenser;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [5:0] refund_units = '0;
  logic       dime_empty = 1'b0;
  logic       nickel_empty = 1'b0;
  logic       eject_ack = 1'b0;
  logic       dime_eject, nickel_eject, busy, done, error;
  logic [5:0] shortfall;

  int n_checks = 0;
  int n_pass   = 0;

  change_dispenser #(
    .UNIT_W(6),
    .EJECT_TIMEOUT(8),
    .GAP_CYCLES(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .refund_units(refund_units),
    .dime_empty(dime_empty),
    .nickel_empty(nickel_empty),
    .eject_ack(eject_ack),
    .dime_eject(dime_eject),
    .nickel_eject(nickel_eject),
    .busy(busy),
    .done(done),
    .shortfall(shortfall),
    .error(error)
  );

  always #5 clock = ~clock;

  typedef struct {
    int units;
    int de;
    int ne;
    int ackd;
    int ackn;
    int restart;
    int exp_d;
    int exp_n;
    int exp_run;
    int exp_short;
    int exp_err;
  } vec_t;

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Runs one payout; acks arrive in the third cycle of each request when enabled.
  task automatic pay(input vec_t v, output int nd, output int nn, output int ndone,
                     output int drun, output int ovl, output int tmo);
    int   hold, dcur, post;
    logic pd, pn, seen;
    nd = 0; nn = 0; ndone = 0; drun = 0; ovl = 0; tmo = 1;
    hold = 0; dcur = 0; post = 0; pd = 1'b0; pn = 1'b0; seen = 1'b0;
    dime_empty   = (v.de != 0);
    nickel_empty = (v.ne != 0);
    refund_units = 6'(v.units);
    start        = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      cycle();
      start = (i == v.restart);
      if (i == v.restart) refund_units = 6'd5;
      eject_ack = 1'b0;
      if (dime_eject && !pd) nd++;
      if (nickel_eject && !pn) nn++;
      if (dime_eject && nickel_eject) ovl = 1;
      dcur = dime_eject ? dcur + 1 : 0;
      if (dcur > drun) drun = dcur;
      if (dime_eject || nickel_eject) hold++;
      else hold = 0;
      if (hold == 3 && ((dime_eject && v.ackd != 0) || (nickel_eject && v.ackn != 0)))
        eject_ack = 1'b1;
      pd = dime_eject;
      pn = nickel_eject;
      if (done) begin
        ndone++;
        seen = 1'b1;
      end else if (seen) begin
        post++;
        if (post == 2) begin
          tmo = 0;
          break;
        end
      end
    end
    start     = 1'b0;
    eject_ack = 1'b0;
  endtask

  initial begin
    vec_t vecs[10];
    vec_t v;
    int   nd, nn, ndone, drun, ovl, tmo, cnt;

    //           units de ne ackd ackn rst  d  n run short err
    vecs[0] = '{ 1,    0, 0, 1,   1,   -1,  0, 1, 0,  0,    0};
    vecs[1] = '{ 3,    0, 0, 1,   1,   -1,  1, 1, 3,  0,    0};
    vecs[2] = '{ 4,    1, 0, 1,   1,   -1,  0, 4, 0,  0,    0};
    vecs[3] = '{ 3,    0, 1, 1,   1,   -1,  1, 0, 3,  1,    1};
    vecs[4] = '{ 2,    0, 0, 0,   1,   -1,  1, 2, 8,  0,    0};
    vecs[5] = '{ 7,    0, 0, 1,   1,   -1,  3, 1, 3,  0,    0};
    vecs[6] = '{ 3,    0, 0, 0,   0,   -1,  1, 1, 8,  3,    1};
    vecs[7] = '{ 5,    1, 1, 1,   1,   -1,  0, 0, 0,  5,    1};
    vecs[8] = '{ 2,    0, 0, 1,   1,    3,  1, 0, 3,  0,    0};
    vecs[9] = '{ 63,   0, 0, 1,   1,   -1, 31, 1, 3,  0,    0};

    repeat (3) cycle();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_dime_eject", int'(dime_eject), 0);
    check("rst_nickel_eject", int'(nickel_eject), 0);
    check("rst_shortfall", int'(shortfall), 0);
    check("rst_error", int'(error), 0);
    reset = 1'b0;
    cycle();

    // Zero refund: busy next cycle, done the cycle after, no coin.
    refund_units = 6'd0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("zero_busy_t1", int'(busy), 1);
    check("zero_done_t1", int'(done), 0);
    cycle();
    check("zero_done_t2", int'(done), 1);
    check("zero_no_eject", int'(dime_eject | nickel_eject), 0);
    check("zero_shortfall", int'(shortfall), 0);
    cycle();
    check("zero_idle_busy", int'(busy), 0);
    check("zero_idle_done", int'(done), 0);

    // Reset in the middle of a nickel eject abandons the payout.
    refund_units = 6'd1;
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    check("first_eject_t2", int'(nickel_eject), 1);
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("rstmid_nickel_eject", int'(nickel_eject), 0);
    check("rstmid_busy", int'(busy), 0);
    check("rstmid_shortfall", int'(shortfall), 0);
    check("rstmid_error", int'(error), 0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (done || busy) cnt++;
      cycle();
    end
    check("rstmid_no_done", cnt, 0);

    foreach (vecs[k]) begin
      v = vecs[k];
      pay(v, nd, nn, ndone, drun, ovl, tmo);
      check($sformatf("v%0d_timeout", k), tmo, 0);
      check($sformatf("v%0d_dimes", k), nd, v.exp_d);
      check($sformatf("v%0d_nickels", k), nn, v.exp_n);
      check($sformatf("v%0d_done_pulses", k), ndone, 1);
      check($sformatf("v%0d_dime_run", k), drun, v.exp_run);
      check($sformatf("v%0d_overlap", k), ovl, 0);
      check($sformatf("v%0d_shortfall", k), int'(shortfall), v.exp_short);
      check($sformatf("v%0d_error", k), int'(error), v.exp_err);
      check($sformatf("v%0d_idle", k), int'(busy), 0);
      cycle();
      cycle();
      check($sformatf("v%0d_short_held", k), int'(shortfall), v.exp_short);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
